// File: rtl/aes_rcon_gen.sv
// Sequential AES round-constant generator: steps a GF(2^8) byte by xtime (forward)
// or inverse xtime (reverse) and streams each constant over a valid/ready handshake.
module aes_rcon_gen #(
  parameter int unsigned WORD_W   = 32,
  parameter logic [7:0]  POLY     = 8'h1b,
  parameter logic [7:0]  POLY_INV = (POLY >> 1) | 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        key_mode,
  input  logic              reverse,
  input  logic              rcon_ready,
  output logic              rcon_valid,
  output logic [WORD_W-1:0] rcon,
  output logic [3:0]        round,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return (b >> 1) ^ (b[0] ? POLY_INV : 8'h00);
  endfunction

  // The n-th constant of the forward schedule, evaluated at elaboration time.
  function automatic logic [7:0] rcon_at(input int n);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 1; i < n; i++) b = xtime(b);
    return b;
  endfunction

  localparam logic [7:0] FINAL_128 = rcon_at(10);
  localparam logic [7:0] FINAL_192 = rcon_at(8);
  localparam logic [7:0] FINAL_256 = rcon_at(7);
  localparam logic [7:0] FINAL_EXT = rcon_at(14);

  function automatic logic [3:0] limit_of(input logic [1:0] mode);
    case (mode)
      2'b00:   return 4'd10;
      2'b01:   return 4'd8;
      2'b10:   return 4'd7;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] final_of(input logic [1:0] mode);
    case (mode)
      2'b00:   return FINAL_128;
      2'b01:   return FINAL_192;
      2'b10:   return FINAL_256;
      default: return FINAL_EXT;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] round_q, round_d;
  logic [3:0] limit_q, limit_d;
  logic       reverse_q, reverse_d;
  logic       is_final;

  assign is_final = reverse_q ? (round_q == 4'd1) : (round_q == limit_q);

  // start wins over a simultaneous accept; mode and direction are frozen until the next start.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    round_d   = round_q;
    limit_d   = limit_q;
    reverse_d = reverse_q;
    if (start) begin
      state_d   = RUN;
      limit_d   = limit_of(key_mode);
      reverse_d = reverse;
      if (reverse) begin
        byte_d  = final_of(key_mode);
        round_d = limit_of(key_mode);
      end else begin
        byte_d  = 8'h01;
        round_d = 4'd1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (rcon_ready) begin
            if (is_final) begin
              state_d = DONE;
            end else if (reverse_q) begin
              byte_d  = inv_xtime(byte_q);
              round_d = round_q - 4'd1;
            end else begin
              byte_d  = xtime(byte_q);
              round_d = round_q + 4'd1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      byte_q    <= 8'h00;
      round_q   <= 4'd0;
      limit_q   <= 4'd0;
      reverse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      round_q   <= round_d;
      limit_q   <= limit_d;
      reverse_q <= reverse_d;
    end
  end

  // Outputs depend only on flops; constant and index read as zero outside RUN.
  always_comb begin
    rcon_valid = (state_q == RUN);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    last       = rcon_valid && is_final;
    round      = rcon_valid ? round_q : 4'd0;
    rcon       = '0;
    if (rcon_valid) rcon[WORD_W-1 -: 8] = byte_q;
  end

endmodule
